frame_copy_master: RTL

- Parametrised Avalon bus-master pixel mover driving the external bus-to-Avalon bridge in Piano_System.
- Copies a rectangular source frame in raster order from the video-in buffer to the VGA pixel buffer, one read and one write per pixel.
- Generalises the top-level copy loop with:
  - configurable geometry and pixel size
  - destination offset with clipping
  - single-shot or continuous mode
  - throttling
  - acknowledge timeout
  - frame status outputs

---
 rtl/frame_copy_master_if.sv | 23 ++
 rtl/frame_copy_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_copy_master_if.sv
// Avalon-style master bus bundle used by frame_copy_master.
// The master modport drives the request side; the slave modport returns ack and read data.
interface frame_copy_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_byte_enable;
    logic              bus_read;
    logic              bus_write;
    logic [31:0]       bus_write_data;
    logic              bus_ack;
    logic [31:0]       bus_read_data;

    modport master (
        output bus_addr, bus_byte_enable, bus_read, bus_write, bus_write_data,
        input  bus_ack, bus_read_data
    );

    modport slave (
        input  bus_addr, bus_byte_enable, bus_read, bus_write, bus_write_data,
        output bus_ack, bus_read_data
    );
endinterface

// File: rtl/frame_copy_master.sv
// Raster-order pixel mover: one bus read then one (possibly clipped) bus write per source pixel.
// Optional macro FRAME_COPY_CHROMA_KEY_EN adds key_color/key_en to suppress writes of keyed pixels.
module frame_copy_master #(
    parameter int ADDR_W          = 32,
    parameter int SRC_WIDTH       = 320,
    parameter int SRC_HEIGHT      = 240,
    parameter int SRC_STRIDE_LOG2 = 9,
    parameter int DST_WIDTH       = 640,
    parameter int DST_HEIGHT      = 480,
    parameter int DST_STRIDE_LOG2 = 10,
    parameter int BPP_BYTES       = 2,
    parameter int THROTTLE        = 3,
    parameter int ACK_TIMEOUT     = 1023
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              single_shot,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [9:0]        dst_x_off,
    input  logic [9:0]        dst_y_off,
`ifdef FRAME_COPY_CHROMA_KEY_EN
    input  logic [31:0]       key_color,
    input  logic              key_en,
`endif
    frame_copy_master_if.master bus,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              timeout_err
);
    localparam int XW       = (SRC_WIDTH  > 1) ? $clog2(SRC_WIDTH)  : 1;
    localparam int YW       = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;
    localparam int TW       = (THROTTLE   > 1) ? $clog2(THROTTLE)   : 1;
    localparam int OW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int BPP_LOG2 = (BPP_BYTES == 4) ? 2 : (BPP_BYTES == 2) ? 1 : 0;
    localparam logic [3:0]  BYTE_EN   = (BPP_BYTES == 4) ? 4'hF : (BPP_BYTES == 2) ? 4'h3 : 4'h1;
    localparam logic [31:0] DATA_MASK = (BPP_BYTES == 4) ? 32'hFFFF_FFFF :
                                        (BPP_BYTES == 2) ? 32'h0000_FFFF : 32'h0000_00FF;

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_RD, S_WR, S_NEXT} state_t;

    state_t            r_state, w_state_nxt;
    logic [XW-1:0]     r_x, w_x_nxt;
    logic [YW-1:0]     r_y, w_y_nxt;
    logic [TW-1:0]     r_gap_cnt, w_gap_cnt_nxt;
    logic [OW-1:0]     r_to_cnt, w_to_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [15:0]       r_count, w_count_nxt;
    logic              r_terr, w_terr_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic              r_read, w_read_nxt;
    logic              r_write, w_write_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;

    logic [10:0]       w_dx, w_dy;
    logic              w_clip, w_keyed, w_skip, w_to_hit, w_last_x, w_last_y;
    logic [31:0]       w_rdata_m;
    logic [ADDR_W-1:0] w_dst_off, w_dst_addr, w_src_off;
    logic              w_launch, w_issue_rd, w_abort;

    assign w_dx       = 11'(r_x) + {1'b0, dst_x_off};
    assign w_dy       = 11'(r_y) + {1'b0, dst_y_off};
    assign w_clip     = ({21'd0, w_dx} >= 32'(DST_WIDTH)) || ({21'd0, w_dy} >= 32'(DST_HEIGHT));
    assign w_rdata_m  = bus.bus_read_data & DATA_MASK;
    assign w_dst_off  = ((ADDR_W'(w_dy) << DST_STRIDE_LOG2) + ADDR_W'(w_dx)) << BPP_LOG2;
    assign w_dst_addr = dst_base + w_dst_off;
    assign w_last_x   = (r_x == XW'(SRC_WIDTH - 1));
    assign w_last_y   = (r_y == YW'(SRC_HEIGHT - 1));
    assign w_to_hit   = (ACK_TIMEOUT != 0) && (r_to_cnt == OW'(ACK_TIMEOUT - 1));

`ifdef FRAME_COPY_CHROMA_KEY_EN
    assign w_keyed = key_en && (w_rdata_m == (key_color & DATA_MASK));
`else
    assign w_keyed = 1'b0;
`endif
    assign w_skip = w_clip || w_keyed;

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one unassigned (no latch).
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_gap_cnt_nxt = r_gap_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_count_nxt   = r_count;
        w_terr_nxt    = r_terr;
        w_addr_nxt    = r_addr;
        w_be_nxt      = r_be;
        w_read_nxt    = r_read;
        w_write_nxt   = r_write;
        w_wdata_nxt   = r_wdata;
        w_launch      = 1'b0;
        w_issue_rd    = 1'b0;
        w_abort       = 1'b0;
        w_src_off     = '0;

        case (r_state)
            S_IDLE: begin
                // A parked frame (busy still high) resumes regardless of mode or start.
                if (enable && (r_busy || !single_shot || start)) begin
                    w_busy_nxt = 1'b1;
                    w_launch   = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == TW'(THROTTLE - 1)) begin
                    if (enable) w_issue_rd  = 1'b1;
                    else        w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + TW'(1);
                end
            end
            S_RD: begin
                if (bus.bus_ack) begin
                    w_read_nxt  = 1'b0;
                    w_wdata_nxt = w_rdata_m;
                    if (w_skip) begin
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_state_nxt  = S_WR;
                        w_write_nxt  = 1'b1;
                        w_addr_nxt   = w_dst_addr;
                        w_to_cnt_nxt = '0;
                    end
                end else if (w_to_hit) begin
                    w_abort = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + OW'(1);
                end
            end
            S_WR: begin
                if (bus.bus_ack) begin
                    w_write_nxt = 1'b0;
                    w_state_nxt = S_NEXT;
                end else if (w_to_hit) begin
                    w_abort = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + OW'(1);
                end
            end
            S_NEXT: begin
                if (w_last_x && w_last_y) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_count + 16'd1;
                    if (!single_shot && enable) begin
                        w_launch = 1'b1;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (w_last_x) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + YW'(1);
                    end else begin
                        w_x_nxt = r_x + XW'(1);
                    end
                    if (enable) w_launch    = 1'b1;
                    else        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_launch) begin
            if (THROTTLE == 0 && enable) begin
                w_issue_rd = 1'b1;
            end else if (THROTTLE == 0) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt   = S_GAP;
                w_gap_cnt_nxt = '0;
            end
        end

        // NOTE: blocking assignments here are ordered on purpose: the read address uses the x/y just updated above.
        if (w_issue_rd) begin
            w_src_off    = ((ADDR_W'(w_y_nxt) << SRC_STRIDE_LOG2) + ADDR_W'(w_x_nxt)) << BPP_LOG2;
            w_state_nxt  = S_RD;
            w_read_nxt   = 1'b1;
            w_be_nxt     = BYTE_EN;
            w_addr_nxt   = src_base + w_src_off;
            w_to_cnt_nxt = '0;
        end

        if (w_abort) begin
            w_read_nxt  = 1'b0;
            w_write_nxt = 1'b0;
            w_terr_nxt  = 1'b1;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_terr    <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_count   <= w_count_nxt;
            r_terr    <= w_terr_nxt;
            r_addr    <= w_addr_nxt;
            r_be      <= w_be_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    assign bus.bus_addr        = r_addr;
    assign bus.bus_byte_enable = r_be;
    assign bus.bus_read        = r_read;
    assign bus.bus_write       = r_write;
    assign bus.bus_write_data  = r_wdata;
    assign busy                = r_busy;
    assign frame_done          = r_done;
    assign frame_count         = r_count;
    assign timeout_err         = r_terr;
endmodule
